// File: rtl/pwm_pkg.sv
// Shared types for the PWM bank: counter mode and count direction.
package pwm_pkg;

    typedef enum logic {
        PwmModeEdge   = 1'b0,
        PwmModeCenter = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: compares the shared counter with its duty value and
// registers the (optionally inverted) result.
module pwm_chan #(
    parameter int CtrSize = 8
) (
    input  logic               clk_sys_i,
    input  logic               rst_sys_i,
    input  logic               en_i,
    input  logic [CtrSize-1:0] count_i,
    input  logic [CtrSize-1:0] duty_i,
    input  logic               polarity_i,
    output logic               modulated_o
);

    logic modulated_d;
    logic modulated_q;

    // While disabled the output rests at the inactive level for this polarity.
    always_comb begin
        modulated_d = polarity_i;
        if (en_i) begin
            modulated_d = (count_i < duty_i) ^ polarity_i;
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            modulated_q <= 1'b0;
        end else begin
            modulated_q <= modulated_d;
        end
    end

    assign modulated_o = modulated_q;

endmodule

// File: rtl/pwm_bank.sv
// Bank of PWM channels sharing one edge- or center-aligned counter, with
// double-buffered settings that take effect only at a period boundary.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int NumChannels = 3,
    parameter int CtrSize     = 8
) (
    input  logic                           clk_sys_i,
    input  logic                           rst_sys_i,
    input  logic                           en_i,
    input  logic                           mode_i,
    input  logic [CtrSize-1:0]             period_i,
    input  logic [NumChannels*CtrSize-1:0] pulse_width_i,
    input  logic [NumChannels-1:0]         polarity_i,
    input  logic                           update_i,
    output logic [NumChannels-1:0]         modulated_o,
    output logic                           period_start_o,
    output logic                           update_ack_o
);

    pwm_mode_e                      modeStage_q;
    logic [CtrSize-1:0]             periodStage_q;
    logic [NumChannels*CtrSize-1:0] dutyStage_q;
    logic [NumChannels-1:0]         polStage_q;

    pwm_mode_e                      modeActive_q;
    logic [CtrSize-1:0]             periodActive_q;
    logic [NumChannels*CtrSize-1:0] dutyActive_q;
    logic [NumChannels-1:0]         polActive_q;

    logic [CtrSize-1:0] count_d, count_q;
    pwm_dir_e           dir_d, dir_q;
    logic               pending_d, pending_q;
    logic               ack_q;
    logic               periodStart_q;
    logic               wrap;
    logic               apply;

    // Counter sequencing; a zero period or a disabled bank pins the count at 0.
    always_comb begin
        count_d = '0;
        dir_d   = DirUp;
        if (en_i && periodActive_q != '0) begin
            if (modeActive_q == PwmModeEdge) begin
                if (count_q < periodActive_q) begin
                    count_d = count_q + CtrSize'(1);
                end
            end else if (dir_q == DirUp && count_q < periodActive_q) begin
                count_d = count_q + CtrSize'(1);
            end else if (dir_q == DirUp) begin
                count_d = periodActive_q - CtrSize'(1);
                dir_d   = DirDown;
            end else begin
                count_d = count_q - CtrSize'(1);
                dir_d   = DirDown;
            end
            if (count_d == '0) begin
                dir_d = DirUp;
            end
        end
    end

    assign wrap      = en_i && (count_d == '0);
    assign apply     = pending_q && (wrap || !en_i);
    assign pending_d = update_i || (pending_q && !apply);

    // A fresh capture coinciding with an apply stays pending for the next boundary.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            modeStage_q    <= PwmModeEdge;
            periodStage_q  <= '0;
            dutyStage_q    <= '0;
            polStage_q     <= '0;
            modeActive_q   <= PwmModeEdge;
            periodActive_q <= '1;
            dutyActive_q   <= '0;
            polActive_q    <= '0;
            count_q        <= '0;
            dir_q          <= DirUp;
            pending_q      <= 1'b0;
            ack_q          <= 1'b0;
            periodStart_q  <= 1'b0;
        end else begin
            if (update_i) begin
                modeStage_q   <= pwm_mode_e'(mode_i);
                periodStage_q <= period_i;
                dutyStage_q   <= pulse_width_i;
                polStage_q    <= polarity_i;
            end
            if (apply) begin
                modeActive_q   <= modeStage_q;
                periodActive_q <= periodStage_q;
                dutyActive_q   <= dutyStage_q;
                polActive_q    <= polStage_q;
            end
            count_q       <= count_d;
            dir_q         <= dir_d;
            pending_q     <= pending_d;
            ack_q         <= apply;
            periodStart_q <= en_i && (count_q == '0);
        end
    end

    for (genvar k = 0; k < NumChannels; k++) begin : gen_chan
        pwm_chan #(
            .CtrSize(CtrSize)
        ) u_chan (
            .clk_sys_i  (clk_sys_i),
            .rst_sys_i  (rst_sys_i),
            .en_i       (en_i),
            .count_i    (count_q),
            .duty_i     (dutyActive_q[k*CtrSize +: CtrSize]),
            .polarity_i (polActive_q[k]),
            .modulated_o(modulated_o[k])
        );
    end

    assign period_start_o = periodStart_q;
    assign update_ack_o   = ack_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: edge/center waveforms, buffered updates,
// polarity with enable low, reset mid-period and zero period.
module tb_pwm_bank;

    logic        clk_sys_i;
    logic        rst_sys_i;
    logic        en_i;
    logic        mode_i;
    logic [7:0]  period_i;
    logic [23:0] pulse_width_i;
    logic [2:0]  polarity_i;
    logic        update_i;
    logic [2:0]  modulated_o;
    logic        period_start_o;
    logic        update_ack_o;

    int assertCount = 0;
    int failCount   = 0;

    pwm_bank #(
        .NumChannels(3),
        .CtrSize    (8)
    ) dut (
        .clk_sys_i     (clk_sys_i),
        .rst_sys_i     (rst_sys_i),
        .en_i          (en_i),
        .mode_i        (mode_i),
        .period_i      (period_i),
        .pulse_width_i (pulse_width_i),
        .polarity_i    (polarity_i),
        .update_i      (update_i),
        .modulated_o   (modulated_o),
        .period_start_o(period_start_o),
        .update_ack_o  (update_ack_o)
    );

    initial clk_sys_i = 1'b0;
    always #5 clk_sys_i = ~clk_sys_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [7:0] p,
                                 input logic [23:0] pw, input logic [2:0] pol);
        mode_i        = m;
        period_i      = p;
        pulse_width_i = pw;
        polarity_i    = pol;
    endtask

    task automatic nextCycle;
        @(negedge clk_sys_i);
    endtask

    // Outputs sampled at a negedge reflect the counter value of the previous cycle.
    initial begin
        logic [7:0] centerCnt [8];
        logic [7:0] c;
        logic [7:0] duty;
        logic [2:0] expMod;
        centerCnt = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1};

        rst_sys_i = 1'b1;
        en_i      = 1'b0;
        update_i  = 1'b0;
        applyStimulus(1'b0, 8'd0, 24'd0, 3'b000);
        nextCycle;
        nextCycle;
        checkOutput("reset_mod", 32'(modulated_o), 32'd0);
        checkOutput("reset_ps", 32'(period_start_o), 32'd0);
        checkOutput("reset_ack", 32'(update_ack_o), 32'd0);
        rst_sys_i = 1'b0;

        // Edge mode P=9, D={12,5,0}, applied while disabled.
        applyStimulus(1'b0, 8'd9, {8'd12, 8'd5, 8'd0}, 3'b000);
        update_i = 1'b1;
        nextCycle;
        checkOutput("edge_capture_ack", 32'(update_ack_o), 32'd0);
        update_i = 1'b0;
        nextCycle;
        checkOutput("edge_apply_ack", 32'(update_ack_o), 32'd1);
        en_i = 1'b1;
        for (int k = 0; k < 30; k++) begin
            nextCycle;
            c = 8'(k % 10);
            checkOutput($sformatf("edge_ps_%0d", k), 32'(period_start_o), 32'(c == 0));
            checkOutput($sformatf("edge_mod_%0d", k), 32'(modulated_o), {29'd0, 1'b1, c < 8'd5, 1'b0});
            checkOutput($sformatf("edge_ack_%0d", k), 32'(update_ack_o), 32'd0);
        end

        // Mid-period update D 5->2 issued while the counter is 3.
        for (int j = 0; j < 20; j++) begin
            nextCycle;
            c    = 8'(j % 10);
            duty = (j < 10) ? 8'd5 : 8'd2;
            checkOutput($sformatf("mid_mod_%0d", j), 32'(modulated_o), {29'd0, 1'b1, c < duty, 1'b0});
            checkOutput($sformatf("mid_ps_%0d", j), 32'(period_start_o), 32'(c == 0));
            checkOutput($sformatf("mid_ack_%0d", j), 32'(update_ack_o), 32'(j == 9));
            if (j == 2) begin
                applyStimulus(1'b0, 8'd9, {8'd12, 8'd2, 8'd0}, 3'b000);
                update_i = 1'b1;
            end
            if (j == 3) update_i = 1'b0;
        end

        // Center mode P=4, D={9,2,0}.
        en_i = 1'b0;
        applyStimulus(1'b1, 8'd4, {8'd9, 8'd2, 8'd0}, 3'b000);
        update_i = 1'b1;
        nextCycle;
        checkOutput("center_dis_ps", 32'(period_start_o), 32'd0);
        checkOutput("center_dis_mod", 32'(modulated_o), 32'd0);
        checkOutput("center_dis_ack", 32'(update_ack_o), 32'd0);
        update_i = 1'b0;
        nextCycle;
        checkOutput("center_apply_ack", 32'(update_ack_o), 32'd1);
        en_i = 1'b1;
        for (int j = 0; j < 16; j++) begin
            nextCycle;
            c = centerCnt[j % 8];
            checkOutput($sformatf("center_mod_%0d", j), 32'(modulated_o), {29'd0, 1'b1, c < 8'd2, 1'b0});
            checkOutput($sformatf("center_ps_%0d", j), 32'(period_start_o), 32'((j % 8) == 0));
        end

        // Polarity 101 with enable low; pending update acks without a wrap.
        en_i = 1'b0;
        applyStimulus(1'b0, 8'd9, {8'd12, 8'd5, 8'd0}, 3'b101);
        update_i = 1'b1;
        nextCycle;
        checkOutput("pol_capture_mod", 32'(modulated_o), 32'd0);
        checkOutput("pol_capture_ps", 32'(period_start_o), 32'd0);
        checkOutput("pol_capture_ack", 32'(update_ack_o), 32'd0);
        update_i = 1'b0;
        nextCycle;
        checkOutput("pol_apply_ack", 32'(update_ack_o), 32'd1);
        nextCycle;
        checkOutput("pol_idle_mod", 32'(modulated_o), 32'd5);
        checkOutput("pol_idle_ps", 32'(period_start_o), 32'd0);
        checkOutput("pol_idle_ack", 32'(update_ack_o), 32'd0);
        en_i = 1'b1;
        for (int j = 0; j < 10; j++) begin
            nextCycle;
            expMod = {1'b1, 8'(j) < 8'd5, 1'b0} ^ 3'b101;
            checkOutput($sformatf("pol_run_mod_%0d", j), 32'(modulated_o), 32'(expMod));
            checkOutput($sformatf("pol_run_ps_%0d", j), 32'(period_start_o), 32'(j == 0));
        end

        // Reset at count 6 with an update pending.
        for (int j = 0; j < 6; j++) begin
            nextCycle;
            expMod = {1'b1, 8'(j) < 8'd5, 1'b0} ^ 3'b101;
            checkOutput($sformatf("pre_rst_mod_%0d", j), 32'(modulated_o), 32'(expMod));
            if (j == 3) begin
                applyStimulus(1'b0, 8'd3, {8'd1, 8'd1, 8'd1}, 3'b000);
                update_i = 1'b1;
            end
            if (j == 4) update_i = 1'b0;
        end
        #2 rst_sys_i = 1'b1;
        #1;
        checkOutput("async_rst_mod", 32'(modulated_o), 32'd0);
        checkOutput("async_rst_ps", 32'(period_start_o), 32'd0);
        checkOutput("async_rst_ack", 32'(update_ack_o), 32'd0);
        nextCycle;
        nextCycle;
        rst_sys_i = 1'b0;
        for (int j = 0; j <= 256; j++) begin
            nextCycle;
            checkOutput($sformatf("post_rst_ps_%0d", j), 32'(period_start_o), 32'((j % 256) == 0));
            checkOutput($sformatf("post_rst_ack_%0d", j), 32'(update_ack_o), 32'd0);
            checkOutput($sformatf("post_rst_mod_%0d", j), 32'(modulated_o), 32'd0);
        end

        // Zero period, D=1 on every channel.
        en_i = 1'b0;
        applyStimulus(1'b0, 8'd0, {8'd1, 8'd1, 8'd1}, 3'b000);
        update_i = 1'b1;
        nextCycle;
        update_i = 1'b0;
        nextCycle;
        checkOutput("p0_apply_ack", 32'(update_ack_o), 32'd1);
        en_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            nextCycle;
            checkOutput($sformatf("p0_ps_%0d", j), 32'(period_start_o), 32'd1);
            checkOutput($sformatf("p0_mod_%0d", j), 32'(modulated_o), 32'd7);
            checkOutput($sformatf("p0_ack_%0d", j), 32'(update_ack_o), 32'd0);
        end

        // Back-to-back updates where the second coincides with a wrap.
        applyStimulus(1'b0, 8'd0, {8'd0, 8'd0, 8'd0}, 3'b000);
        update_i = 1'b1;
        nextCycle;
        checkOutput("wrap_first_ack", 32'(update_ack_o), 32'd0);
        checkOutput("wrap_first_mod", 32'(modulated_o), 32'd7);
        applyStimulus(1'b0, 8'd0, {8'd0, 8'd0, 8'd1}, 3'b000);
        nextCycle;
        checkOutput("wrap_second_ack", 32'(update_ack_o), 32'd1);
        checkOutput("wrap_second_mod", 32'(modulated_o), 32'd7);
        update_i = 1'b0;
        nextCycle;
        checkOutput("wrap_third_ack", 32'(update_ack_o), 32'd1);
        checkOutput("wrap_third_mod", 32'(modulated_o), 32'd0);
        nextCycle;
        checkOutput("wrap_final_ack", 32'(update_ack_o), 32'd0);
        checkOutput("wrap_final_mod", 32'(modulated_o), 32'd1);
        checkOutput("wrap_final_ps", 32'(period_start_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
